// File: rtl/cru_peri_clkrst_ch_if.sv
// Configuration write port of the peri CRU channel bank.
// With CRU_PERI_ERR_EN defined the port also carries the cfg_err pulse.
interface cru_peri_clkrst_ch_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 8,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_gate;
    logic             cfg_srst;
    logic             cfg_rdy;
`ifdef CRU_PERI_ERR_EN
    logic             cfg_err;

    modport master (output cfg_wr, cfg_ch, cfg_div, cfg_gate, cfg_srst,
                    input  cfg_rdy, cfg_err);
    modport slave  (input  cfg_wr, cfg_ch, cfg_div, cfg_gate, cfg_srst,
                    output cfg_rdy, cfg_err);
`else
    modport master (output cfg_wr, cfg_ch, cfg_div, cfg_gate, cfg_srst,
                    input  cfg_rdy);
    modport slave  (input  cfg_wr, cfg_ch, cfg_div, cfg_gate, cfg_srst,
                    output cfg_rdy);
`endif
endinterface

// File: rtl/cru_peri_clkrst_ch.sv
// Peri CRU channel bank: NCH channels, each with an integer divider
// (enable strobe + registered divided clock level), a glitch-free gate and
// a soft-reset sequencer releasing reset aligned to the divided clock.
// Optional feature macro: CRU_PERI_ERR_EN (adds the cfg_err pulse).

// One channel: divider, gate, pending-config register and reset sequencer.
module cru_peri_clkrst_lane #(
    parameter int DIV_W    = 8,
    parameter int DIV_DEF  = 0,
    parameter int HOLD_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,        // accepted write aimed at this channel
    input  logic [DIV_W-1:0] wdiv,
    input  logic             wgate,
    input  logic             wsrst,
    output logic             pend,
    output logic             idle,
    output logic             en,
    output logic             div_clk,
    output logic             lane_rst,
    output logic             done
);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE, S_DONE} state_t;

    logic [DIV_W-1:0] cnt, div, pend_div;
    logic             gate, pend_gate;
    logic             wrap, upd, gate_n, clk_n;
    logic [DIV_W-1:0] cnt_n, div_n, half;
    logic [DIV_W:0]   ratio_n;

    state_t           state, state_n;
    logic [HW-1:0]    hold, hold_n;

    // Divider next state; pending config lands at wrap, or at once while gated.
    always_comb begin
        wrap    = ~gate & (cnt == div);
        upd     = pend & (gate | wrap);
        div_n   = upd ? pend_div  : div;
        gate_n  = upd ? pend_gate : gate;
        cnt_n   = (gate | wrap) ? '0 : cnt + DIV_W'(1);
        ratio_n = {1'b0, div_n} + (DIV_W+1)'(1);
        half    = DIV_W'(ratio_n >> 1);
        clk_n   = ~gate_n & (cnt_n >= half);
    end

    // Divider, gate and pending-config registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            div       <= DIV_W'(DIV_DEF);
            gate      <= 1'b0;
            pend      <= 1'b0;
            pend_div  <= DIV_W'(DIV_DEF);
            pend_gate <= 1'b0;
            en        <= 1'b0;
            div_clk   <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            div     <= div_n;
            gate    <= gate_n;
            en      <= wrap;
            div_clk <= clk_n;
            // wr only happens with pend clear, upd only with pend set
            if (upd) pend <= 1'b0;
            if (wr) begin
                pend      <= 1'b1;
                pend_div  <= wdiv;
                pend_gate <= wgate;
            end
        end
    end

    // Reset sequencer state register; rst parks every channel in ASSERT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ASSERT;
            hold  <= '0;
        end else begin
            state <= state_n;
            hold  <= hold_n;
        end
    end

    // Reset sequencer next state and Moore outputs.
    always_comb begin
        state_n  = state;
        hold_n   = hold;
        lane_rst = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr & wsrst) begin
                    state_n = S_ASSERT;
                    hold_n  = '0;
                end
            end
            S_ASSERT: begin
                lane_rst = 1'b1;
                if (hold == HW'(HOLD_CYC - 1)) begin
                    state_n = S_RELEASE;
                    hold_n  = '0;
                end else begin
                    hold_n = hold + HW'(1);
                end
            end
            S_RELEASE: begin
                lane_rst = 1'b1;
                // a gated channel never strobes, so release right away
                if (en | gate) state_n = S_DONE;
            end
            default: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

    assign idle = (state == S_IDLE);
endmodule

// Channel bank top: config decode and per-channel lane array.
module cru_peri_clkrst_ch #(
    parameter int NCH      = 4,
    parameter int DIV_W    = 8,
    parameter int DIV_DEF  = 0,
    parameter int HOLD_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cru_peri_clkrst_ch_if.slave    cfg,
    output logic [NCH-1:0]         ch_en,
    output logic [NCH-1:0]         ch_clk,
    output logic [NCH-1:0]         ch_rst,
    output logic [NCH-1:0]         ch_rst_done
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic           oob, sel_pend, rdy, acc;
    logic [NCH-1:0] pend, idle, wr;

    assign oob = ({{(32-CH_W){1'b0}}, cfg.cfg_ch} >= 32'(NCH));

    // Pick the addressed channel's pending flag; out-of-range never stalls.
    always_comb begin
        sel_pend = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (!oob && cfg.cfg_ch == CH_W'(i)) sel_pend = pend[i];
    end

    assign rdy         = oob | ~sel_pend;
    assign cfg.cfg_rdy = rdy;
    assign acc         = cfg.cfg_wr & rdy;

    // One-hot accepted-write strobe per channel; out-of-range writes vanish.
    always_comb begin
        wr = '0;
        for (int i = 0; i < NCH; i++)
            wr[i] = acc & ~oob & (cfg.cfg_ch == CH_W'(i));
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        cru_peri_clkrst_lane #(
            .DIV_W   (DIV_W),
            .DIV_DEF (DIV_DEF),
            .HOLD_CYC(HOLD_CYC)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr      (wr[g]),
            .wdiv    (cfg.cfg_div),
            .wgate   (cfg.cfg_gate),
            .wsrst   (cfg.cfg_srst),
            .pend    (pend[g]),
            .idle    (idle[g]),
            .en      (ch_en[g]),
            .div_clk (ch_clk[g]),
            .lane_rst(ch_rst[g]),
            .done    (ch_rst_done[g])
        );
    end

`ifdef CRU_PERI_ERR_EN
    logic sel_idle, err;

    // Addressed channel's sequencer idle flag, for dropped-srst detection.
    always_comb begin
        sel_idle = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (!oob && cfg.cfg_ch == CH_W'(i)) sel_idle = idle[i];
    end

    // Error pulse one cycle after an out-of-range write or a dropped srst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= acc & (oob | (cfg.cfg_srst & ~sel_idle));
    end

    assign cfg.cfg_err = err;
`else
    // idle is only consumed by the error logic
    logic unused_idle;
    assign unused_idle = ^idle;
`endif
endmodule
